// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic array operand feeder: default geometry,
// feeder state encoding and the drain-window length rule.
package systolic_pkg;

  localparam int N_DEF = 3;
  localparam int W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } feed_state_e;

  // Zero-fill long enough for partial sums to clear the PE mult/add pipeline.
  function automatic int drain_cyc_default(input int n);
    return 2 * n + 2;
  endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Write port and edge-stream bundle between the feeder and its host/array.
interface systolic_feeder_if #(
  parameter int N = 3,
  parameter int W = 8
) ();
  localparam int IW = $clog2(N);

  logic            wr_en;
  logic            wr_sel;
  logic [IW-1:0]   wr_row;
  logic [IW-1:0]   wr_col;
  logic [W-1:0]    wr_data;
  logic            start;
  logic            busy;
  logic            feed_valid;
  logic [N*W-1:0]  a_out;
  logic [N*W-1:0]  b_out;
  logic            done;

  modport master (
    output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    input  busy, feed_valid, a_out, b_out, done
  );

  modport slave (
    input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    output busy, feed_valid, a_out, b_out, done
  );
endinterface

// File: rtl/systolic_feeder_operand_buffer.sv
// N x N operand register file with one write port and N diagonal read lanes.
// Row mode: lane i = M[i][t-i]; column mode: lane j = M[t-j][j].
module operand_buffer
  import systolic_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int W        = W_DEF,
  parameter int IW       = $clog2(N),
  parameter int TW       = $clog2(3 * N - 1),
  parameter bit COL_MODE = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_en,
  input  logic [IW-1:0]  wr_row,
  input  logic [IW-1:0]  wr_col,
  input  logic [W-1:0]   wr_data,
  input  logic [TW-1:0]  rd_t,
  output logic [N*W-1:0] rd_lanes
);

  logic [W-1:0] mem_q [N][N];
  logic [W-1:0] mem_d [N][N];

  // Next contents; out-of-range indices are silently dropped.
  always_comb begin
    mem_d = mem_q;
    if (wr_en && (int'(wr_row) < N) && (int'(wr_col) < N)) begin
      mem_d[wr_row][wr_col] = wr_data;
    end else begin
      mem_d = mem_q;
    end
  end

  // Storage flops, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          mem_q[r][c] <= {W{1'b0}};
        end
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Lanes read the post-write view so a write on the start edge reaches beat 0.
  always_comb begin
    int              d;
    logic [IW-1:0]   di;
    logic [IW-1:0]   li;
    rd_lanes = '0;
    for (int i = 0; i < N; i++) begin
      d  = int'(rd_t) - i;
      di = IW'(d);
      li = IW'(i);
      if ((d >= 0) && (d < N)) begin
        rd_lanes[i*W +: W] = COL_MODE ? mem_d[di][li] : mem_d[li][di];
      end else begin
        rd_lanes[i*W +: W] = {W{1'b0}};
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder: buffers A and B, streams them skewed into the array edges,
// zero-fills a drain window, then pulses done.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int W         = W_DEF,
  parameter int DRAIN_CYC = drain_cyc_default(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  systolic_feeder_if.slave bus
);

  localparam int IW = $clog2(N);
  localparam int TW = $clog2(3 * N - 1);
  localparam int DW = $clog2(DRAIN_CYC + 1);
  localparam logic [TW-1:0] LAST_T     = TW'(3 * N - 3);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

  feed_state_e     state_q, state_d;
  logic [TW-1:0]   t_q, t_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic            busy_q, busy_d;
  logic            feed_valid_q, feed_valid_d;
  logic            done_q, done_d;
  logic [N*W-1:0]  a_out_q, a_out_d;
  logic [N*W-1:0]  b_out_q, b_out_d;
  logic [N*W-1:0]  a_lanes, b_lanes;
  logic            wr_ok;

  assign wr_ok = bus.wr_en && (state_q == ST_IDLE);

  operand_buffer #(.N(N), .W(W), .IW(IW), .TW(TW), .COL_MODE(1'b0)) u_buf_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_ok && !bus.wr_sel),
    .wr_row   (bus.wr_row),
    .wr_col   (bus.wr_col),
    .wr_data  (bus.wr_data),
    .rd_t     (t_d),
    .rd_lanes (a_lanes)
  );

  operand_buffer #(.N(N), .W(W), .IW(IW), .TW(TW), .COL_MODE(1'b1)) u_buf_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_ok && bus.wr_sel),
    .wr_row   (bus.wr_row),
    .wr_col   (bus.wr_col),
    .wr_data  (bus.wr_data),
    .rd_t     (t_d),
    .rd_lanes (b_lanes)
  );

  // Sequencing; outputs are precomputed from the next state so they register
  // in step with it and beat 0 appears the cycle after start.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_FEED;
          t_d     = {TW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FEED: begin
        if (t_q == LAST_T) begin
          state_d = ST_DRAIN;
          drain_d = {DW{1'b0}};
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    feed_valid_d = (state_d == ST_FEED);
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
    a_out_d      = feed_valid_d ? a_lanes : {(N*W){1'b0}};
    b_out_d      = feed_valid_d ? b_lanes : {(N*W){1'b0}};
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      t_q          <= {TW{1'b0}};
      drain_q      <= {DW{1'b0}};
      busy_q       <= 1'b0;
      feed_valid_q <= 1'b0;
      done_q       <= 1'b0;
      a_out_q      <= {(N*W){1'b0}};
      b_out_q      <= {(N*W){1'b0}};
    end else begin
      state_q      <= state_d;
      t_q          <= t_d;
      drain_q      <= drain_d;
      busy_q       <= busy_d;
      feed_valid_q <= feed_valid_d;
      done_q       <= done_d;
      a_out_q      <= a_out_d;
      b_out_q      <= b_out_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.feed_valid = feed_valid_q;
  assign bus.done       = done_q;
  assign bus.a_out      = a_out_q;
  assign bus.b_out      = b_out_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed + randomized bench for systolic_feeder against a matrix-level model.
module tb_systolic_feeder;
  localparam int N    = 3;
  localparam int W    = 8;
  localparam int DC   = 8;
  localparam int FEED = 3 * N - 2;
  localparam int RUN  = FEED + DC + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  systolic_feeder_if #(.N(N), .W(W)) bus ();
  systolic_feeder #(.N(N), .W(W), .DRAIN_CYC(DC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int tests = 0;
  int fails = 0;
  logic [W-1:0] ma [N][N];
  logic [W-1:0] mb [N][N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] exp_a(input int t);
    logic [N*W-1:0] v = '0;
    for (int i = 0; i < N; i++)
      if (t - i >= 0 && t - i < N) v[i*W +: W] = ma[i][t-i];
    return v;
  endfunction

  function automatic logic [N*W-1:0] exp_b(input int t);
    logic [N*W-1:0] v = '0;
    for (int j = 0; j < N; j++)
      if (t - j >= 0 && t - j < N) v[j*W +: W] = mb[t-j][j];
    return v;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = '0;
        mb[r][c] = '0;
      end
  endtask

  task automatic model_write(input bit sel, input int r, input int c, input logic [W-1:0] d);
    if (r < N && c < N) begin
      if (sel) mb[r][c] = d;
      else     ma[r][c] = d;
    end
  endtask

  task automatic set_wr(input bit sel, input int r, input int c, input logic [W-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_row  = 2'(r);
    bus.wr_col  = 2'(c);
    bus.wr_data = d;
  endtask

  // Entered and left at a falling edge.
  task automatic write(input bit sel, input int r, input int c, input logic [W-1:0] d);
    set_wr(sel, r, c, d);
    model_write(sel, r, c, d);
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic run_feed(input bit directed, input bit lockout,
                          input bit ws, input bit ws_sel, input int ws_r, input int ws_c,
                          input logic [W-1:0] ws_d);
    bus.start = 1'b1;
    if (ws) begin
      set_wr(ws_sel, ws_r, ws_c, ws_d);
      model_write(ws_sel, ws_r, ws_c, ws_d);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    for (int c = 1; c <= RUN; c++) begin
      bit in_feed;
      in_feed = (c <= FEED);
      check("feed_valid", 64'(bus.feed_valid), 64'(in_feed));
      check("busy", 64'(bus.busy), 64'(1'b1));
      check("done", 64'(bus.done), 64'(c == RUN));
      check("a_out", 64'(bus.a_out), in_feed ? 64'(exp_a(c - 1)) : 64'd0);
      check("b_out", 64'(bus.b_out), in_feed ? 64'(exp_b(c - 1)) : 64'd0);
      if (directed) begin
        if (c == 1) check("beat0_a", 64'(bus.a_out), 64'h000001);
        if (c == 1) check("beat0_b", 64'(bus.b_out), 64'h000011);
        if (c == 3) check("beat2_a", 64'(bus.a_out), 64'h070503);
        if (c == 5) check("beat4_a", 64'(bus.a_out), 64'h090000);
        if (c == 5) check("beat4_b", 64'(bus.b_out), 64'h190000);
      end
      if (lockout && c == 3) begin
        set_wr(1'b0, 0, 0, 8'hFF);
        bus.start = 1'b1;
      end else begin
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    check("busy_after", 64'(bus.busy), 64'd0);
    check("done_after", 64'(bus.done), 64'd0);
    check("fv_after", 64'(bus.feed_valid), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_fv"}, 64'(bus.feed_valid), 64'd0);
    check({tag, "_done"}, 64'(bus.done), 64'd0);
    check({tag, "_a"}, 64'(bus.a_out), 64'd0);
    check({tag, "_b"}, 64'(bus.b_out), 64'd0);
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_sel  = 1'b0;
    bus.wr_row  = 2'd0;
    bus.wr_col  = 2'd0;
    bus.wr_data = 8'd0;
    bus.start   = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Test-plan matrices, row-major.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        write(1'b0, r, c, 8'(8'h01 + r * N + c));
        write(1'b1, r, c, 8'(8'h11 + r * N + c));
      end
    run_feed(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 8'h00);
    run_feed(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 8'h00);
    run_feed(1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 8'hAA);

    write(1'b0, 3, 0, 8'h5A);
    write(1'b1, 1, 3, 8'hA5);
    run_feed(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 8'h00);

    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 2 * N * N + 4; n++)
        write(1'($urandom), int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
              8'($urandom));
      run_feed(1'b0, 1'b0, 1'($urandom), 1'($urandom), int'($urandom_range(3, 0)),
               int'($urandom_range(3, 0)), 8'($urandom));
    end

    // Reset during beat 3.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c < 4; c++) @(negedge clk);
    check("pre_reset_fv", 64'(bus.feed_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_feed(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
